// File: rtl/led_pio_scheduler.sv
// Arbitrates the LED PIO write port between the Nios host and a prescaled pattern sequencer.
// Optional macro LED_SCHED_STATUS_EN: host reads of address 3 return a local status word instead of the PIO.
module led_pio_scheduler #(
    parameter int LED_WIDTH    = 10,
    parameter int PRESCALE_W   = 24,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            host_address,
    input  logic                  host_chipselect,
    input  logic                  host_write_n,
    input  logic [31:0]           host_writedata,
    output logic [31:0]           host_readdata,
    output logic                  host_waitrequest,
    output logic [1:0]            pio_address,
    output logic                  pio_chipselect,
    output logic                  pio_write_n,
    output logic [31:0]           pio_writedata,
    input  logic [31:0]           pio_readdata,
    input  logic                  seq_enable,
    input  logic [1:0]            seq_mode,
    input  logic [PRESCALE_W-1:0] seq_period,
    output logic                  seq_tick,
    output logic [LED_WIDTH-1:0]  seq_pattern
);

    localparam int STARVE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SEQ_WR = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [LED_WIDTH-1:0]   pattern_reg, pattern_next;
    logic                   pending_reg, pending_next;
    logic [PRESCALE_W-1:0]  cnt_reg, cnt_next;
    logic [STARVE_W-1:0]    starve_reg, starve_next;
    logic                   tick_reg;

    logic                   tick_now;
    logic                   host_wr0;
    logic                   seq_update;
    logic                   starve_hit;
    logic [LED_WIDTH-1:0]   base;
    logic [LED_WIDTH-1:0]   rot;

    assign tick_now   = seq_enable &&
                        ((seq_period <= PRESCALE_W'(1)) || (cnt_reg == seq_period - PRESCALE_W'(1)));
    // A host write only lands when it is not being stalled by a sequencer cycle.
    assign host_wr0   = (state_reg == IDLE) && host_chipselect && !host_write_n && (host_address == 2'd0);
    assign base       = host_wr0 ? host_writedata[LED_WIDTH-1:0] : pattern_reg;
    assign seq_update = tick_now && (seq_mode != 2'b00);
    assign starve_hit = (starve_reg == STARVE_W'(STARVE_LIMIT - 1));
    assign cnt_next   = tick_now || !seq_enable ? '0 : cnt_reg + PRESCALE_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < LED_WIDTH; gi++) begin : g_rot
            if (gi == 0) begin : g_wrap
                assign rot[gi] = base[LED_WIDTH-1];
            end else begin : g_shift
                assign rot[gi] = base[gi-1];
            end
        end
    endgenerate

    always_comb begin
        pattern_next = base;
        if (tick_now) begin
            case (seq_mode)
                2'b01:   pattern_next = (base == '0) ? LED_WIDTH'(1) : rot;
                2'b10:   pattern_next = ~base;
                2'b11:   pattern_next = base + LED_WIDTH'(1);
                default: pattern_next = base;
            endcase
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg | seq_update;
        starve_next  = '0;
        case (state_reg)
            IDLE: begin
                if (pending_reg) begin
                    if (!host_chipselect || starve_hit) begin
                        state_next = SEQ_WR;
                    end else begin
                        starve_next = starve_reg + STARVE_W'(1);
                    end
                end
            end
            SEQ_WR: begin
                state_next   = IDLE;
                // The write now on the bus carries the old pattern; a fresh update re-arms it.
                pending_next = seq_update;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            pattern_reg <= '0;
            pending_reg <= 1'b0;
            cnt_reg     <= '0;
            starve_reg  <= '0;
            tick_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pattern_reg <= pattern_next;
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            starve_reg  <= starve_next;
            tick_reg    <= tick_now;
        end
    end

`ifdef LED_SCHED_STATUS_EN
    logic        status_rd;
    logic [31:0] status_word;

    assign status_rd = host_chipselect && host_write_n && (host_address == 2'd3);

    always_comb begin
        status_word                  = '0;
        status_word[31:27]           = {pending_reg, state_reg == SEQ_WR, seq_enable, seq_mode};
        status_word[LED_WIDTH-1:0]   = pattern_reg;
    end
`endif

    always_comb begin
        pio_address      = host_address;
        pio_chipselect   = host_chipselect;
        pio_write_n      = host_write_n;
        pio_writedata    = host_writedata;
        host_readdata    = pio_readdata;
        host_waitrequest = 1'b0;
        if (state_reg == SEQ_WR) begin
            pio_address      = 2'd0;
            pio_chipselect   = 1'b1;
            pio_write_n      = 1'b0;
            pio_writedata    = 32'(pattern_reg);
            host_waitrequest = host_chipselect;
        end
`ifdef LED_SCHED_STATUS_EN
        else if (status_rd) begin
            pio_chipselect = 1'b0;
            host_readdata  = status_word;
        end
`endif
    end

    assign seq_tick    = tick_reg;
    assign seq_pattern = pattern_reg;

endmodule

// File: tb/tb_led_pio_scheduler.sv
// Directed, table-driven bench for led_pio_scheduler; one vector per clock cycle,
// outputs sampled on the falling edge.
module tb_led_pio_scheduler;

    localparam logic [31:0] PIO_RD = 32'hCAFE_0000;

    logic        clk;
    logic        reset;
    logic [1:0]  host_address;
    logic        host_chipselect;
    logic        host_write_n;
    logic [31:0] host_writedata;
    logic [31:0] host_readdata;
    logic        host_waitrequest;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        seq_enable;
    logic [1:0]  seq_mode;
    logic [23:0] seq_period;
    logic        seq_tick;
    logic [9:0]  seq_pattern;

    int tests_run = 0;
    int tests_failed = 0;

    led_pio_scheduler #(
        .LED_WIDTH(10),
        .PRESCALE_W(24),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .host_address(host_address),
        .host_chipselect(host_chipselect),
        .host_write_n(host_write_n),
        .host_writedata(host_writedata),
        .host_readdata(host_readdata),
        .host_waitrequest(host_waitrequest),
        .pio_address(pio_address),
        .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n),
        .pio_writedata(pio_writedata),
        .pio_readdata(pio_readdata),
        .seq_enable(seq_enable),
        .seq_mode(seq_mode),
        .seq_period(seq_period),
        .seq_tick(seq_tick),
        .seq_pattern(seq_pattern)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rst;
        logic        en;
        logic [1:0]  mode;
        logic [23:0] per;
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        e_cs;
        logic        e_wn;
        logic [1:0]  e_addr;
        logic [31:0] e_wd;
        logic        e_wait;
        logic        e_tick;
        logic [9:0]  e_pat;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic rst, input logic en, input logic [1:0] mode,
                                input logic [23:0] per, input logic cs, input logic wn, input logic [1:0] addr,
                                input logic [31:0] wd, input logic e_cs, input logic e_wn, input logic [1:0] e_addr,
                                input logic [31:0] e_wd, input logic e_wait, input logic e_tick, input logic [9:0] e_pat);
        vec_t v;
        v.nm = nm; v.rst = rst; v.en = en; v.mode = mode; v.per = per;
        v.cs = cs; v.wn = wn; v.addr = addr; v.wd = wd;
        v.e_cs = e_cs; v.e_wn = e_wn; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_wait = e_wait; v.e_tick = e_tick; v.e_pat = e_pat; v.e_rd = PIO_RD;
        return v;
    endfunction

    // Drive at posedge+1, sample at the following negedge, then advance one cycle.
    task automatic apply(input vec_t v);
        logic [80:0] act;
        logic [80:0] exp;
        reset           = v.rst;
        seq_enable      = v.en;
        seq_mode        = v.mode;
        seq_period      = v.per;
        host_chipselect = v.cs;
        host_write_n    = v.wn;
        host_address    = v.addr;
        host_writedata  = v.wd;
        @(negedge clk);
        act = {pio_chipselect, pio_write_n, pio_address, pio_writedata, host_waitrequest, seq_tick,
               seq_pattern, host_readdata};
        exp = {v.e_cs, v.e_wn, v.e_addr, v.e_wd, v.e_wait, v.e_tick, v.e_pat, v.e_rd};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got cs=%b wn=%b addr=%0d wd=%h wait=%b tick=%b pat=%h rd=%h; want cs=%b wn=%b addr=%0d wd=%h wait=%b tick=%b pat=%h rd=%h",
                     v.nm, pio_chipselect, pio_write_n, pio_address, pio_writedata, host_waitrequest, seq_tick,
                     seq_pattern, host_readdata, v.e_cs, v.e_wn, v.e_addr, v.e_wd, v.e_wait, v.e_tick, v.e_pat, v.e_rd);
        end else begin
            $display("[TB] ok %s: cs=%b wn=%b addr=%0d wd=%h wait=%b tick=%b pat=%h",
                     v.nm, pio_chipselect, pio_write_n, pio_address, pio_writedata, host_waitrequest, seq_tick,
                     seq_pattern);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        pio_readdata    = PIO_RD;
        reset           = 1'b1;
        seq_enable      = 1'b0;
        seq_mode        = 2'b00;
        seq_period      = '0;
        host_chipselect = 1'b0;
        host_write_n    = 1'b1;
        host_address    = 2'd0;
        host_writedata  = '0;
        repeat (2) @(posedge clk);
        #1;

        //        name          rst en md per  cs wn ad wd             ecs ewn ead ewd            wt tk pat
        vecs.push_back(mk("reset",      1, 0, 0, 0,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h000));
        vecs.push_back(mk("cnt_c0",     0, 1, 3, 4,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h000));
        vecs.push_back(mk("cnt_c1",     0, 1, 3, 4,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h000));
        vecs.push_back(mk("cnt_c2",     0, 1, 3, 4,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h000));
        vecs.push_back(mk("cnt_c3",     0, 1, 3, 4,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h000));
        vecs.push_back(mk("cnt_tick1",  0, 1, 3, 4,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 1, 10'h001));
        vecs.push_back(mk("cnt_wr1",    0, 1, 3, 4,  0, 1, 0, 32'h0,          1, 0, 0, 32'h1,          0, 0, 10'h001));
        vecs.push_back(mk("cnt_c6",     0, 1, 3, 4,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h001));
        vecs.push_back(mk("cnt_c7",     0, 1, 3, 4,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h001));
        vecs.push_back(mk("cnt_tick2",  0, 1, 3, 4,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 1, 10'h002));
        vecs.push_back(mk("cnt_wr2",    0, 1, 3, 4,  0, 1, 0, 32'h0,          1, 0, 0, 32'h2,          0, 0, 10'h002));
        vecs.push_back(mk("cnt_c10",    0, 1, 3, 4,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h002));
        vecs.push_back(mk("cnt_c11",    0, 1, 3, 4,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h002));
        vecs.push_back(mk("cnt_tick3",  0, 1, 3, 4,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 1, 10'h003));
        vecs.push_back(mk("cnt_wr3",    0, 1, 3, 4,  0, 1, 0, 32'h0,          1, 0, 0, 32'h3,          0, 0, 10'h003));
        vecs.push_back(mk("chase_load", 0, 0, 1, 4,  1, 0, 0, 32'h200,        1, 0, 0, 32'h200,        0, 0, 10'h003));
        vecs.push_back(mk("chase_c0",   0, 1, 1, 2,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h200));
        vecs.push_back(mk("chase_c1",   0, 1, 1, 2,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h200));
        vecs.push_back(mk("chase_wrap", 0, 0, 1, 2,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 1, 10'h001));
        vecs.push_back(mk("chase_wr",   0, 0, 1, 2,  0, 1, 0, 32'h0,          1, 0, 0, 32'h1,          0, 0, 10'h001));
        vecs.push_back(mk("zero_load",  0, 0, 1, 2,  1, 0, 0, 32'h0,          1, 0, 0, 32'h0,          0, 0, 10'h001));
        vecs.push_back(mk("zero_c0",    0, 1, 1, 1,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h000));
        vecs.push_back(mk("zero_tick",  0, 0, 1, 1,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 1, 10'h001));
        vecs.push_back(mk("zero_wr",    0, 0, 1, 1,  0, 1, 0, 32'h0,          1, 0, 0, 32'h1,          0, 0, 10'h001));
        vecs.push_back(mk("read_pass",  0, 0, 1, 1,  1, 1, 1, 32'h0,          1, 1, 1, 32'h0,          0, 0, 10'h001));
        vecs.push_back(mk("blink_c0",   0, 1, 2, 2,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h001));
        vecs.push_back(mk("blink_host", 0, 1, 2, 2,  1, 0, 0, 32'hABCD0155,   1, 0, 0, 32'hABCD0155,   0, 0, 10'h001));
        vecs.push_back(mk("blink_tick", 0, 0, 2, 2,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 1, 10'h2AA));
        vecs.push_back(mk("blink_wr",   0, 0, 2, 2,  0, 1, 0, 32'h0,          1, 0, 0, 32'h2AA,        0, 0, 10'h2AA));
        vecs.push_back(mk("wrap_load",  0, 0, 3, 1,  1, 0, 0, 32'h3FF,        1, 0, 0, 32'h3FF,        0, 0, 10'h2AA));
        vecs.push_back(mk("wrap_c0",    0, 1, 3, 1,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h3FF));
        vecs.push_back(mk("wrap_tick",  0, 0, 3, 1,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 1, 10'h000));
        vecs.push_back(mk("wrap_wr",    0, 0, 3, 1,  0, 1, 0, 32'h0,          1, 0, 0, 32'h0,          0, 0, 10'h000));
        vecs.push_back(mk("hold_c0",    0, 1, 0, 1,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h000));
        vecs.push_back(mk("hold_tick",  0, 0, 0, 1,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 1, 10'h000));
        vecs.push_back(mk("hold_nowr",  0, 0, 0, 1,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 10'h000));

        foreach (vecs[i]) apply(vecs[i]);

        // Host holds chipselect while a sequencer write is pending.
        apply(mk("starve_arm",  0, 1, 3, 1, 1, 1, 2, 32'h0, 1, 1, 2, 32'h0, 0, 0, 10'h000));
        apply(mk("starve_blk0", 0, 0, 3, 1, 1, 1, 2, 32'h0, 1, 1, 2, 32'h0, 0, 1, 10'h001));
        for (int k = 1; k < 4; k++) begin
            apply(mk($sformatf("starve_blk%0d", k), 0, 0, 3, 1, 1, 1, 2, 32'h0, 1, 1, 2, 32'h0, 0, 0, 10'h001));
        end
        apply(mk("starve_force", 0, 0, 3, 1, 1, 0, 0, 32'h0AA, 1, 0, 0, 32'h1,   1, 0, 10'h001));
        apply(mk("stall_done",   0, 0, 3, 1, 1, 0, 0, 32'h0AA, 1, 0, 0, 32'h0AA, 0, 0, 10'h001));
        apply(mk("host_wins",    0, 0, 3, 1, 0, 1, 0, 32'h0,   0, 1, 0, 32'h0,   0, 0, 10'h0AA));

        // Reset landing on a sequencer write cycle.
        apply(mk("rst_arm",   0, 1, 3, 1, 0, 1, 0, 32'h0, 0, 1, 0, 32'h0,   0, 0, 10'h0AA));
        apply(mk("rst_tick",  0, 0, 3, 1, 0, 1, 0, 32'h0, 0, 1, 0, 32'h0,   0, 1, 10'h0AB));
        apply(mk("rst_in_wr", 1, 0, 3, 1, 0, 1, 0, 32'h0, 1, 0, 0, 32'h0AB, 0, 0, 10'h0AB));
        apply(mk("rst_drop",  0, 0, 3, 1, 0, 1, 0, 32'h0, 0, 1, 0, 32'h0,   0, 0, 10'h000));
        apply(mk("rst_noretry", 0, 0, 3, 1, 0, 1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 10'h000));

        // Address 3 read: status word when enabled, plain passthrough otherwise.
        apply(mk("st_load", 0, 0, 2, 1000, 1, 0, 0, 32'h0F0, 1, 0, 0, 32'h0F0, 0, 0, 10'h000));
`ifdef LED_SCHED_STATUS_EN
        v = mk("st_read", 0, 1, 2, 1000, 1, 1, 3, 32'h0, 0, 1, 3, 32'h0, 0, 0, 10'h0F0);
        v.e_rd = 32'h3000_00F0;
`else
        v = mk("st_read", 0, 1, 2, 1000, 1, 1, 3, 32'h0, 1, 1, 3, 32'h0, 0, 0, 10'h0F0);
`endif
        apply(v);
        apply(mk("st_idle", 0, 0, 2, 1000, 0, 1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 10'h0F0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
